// File: rtl/iq_mixer_accum.sv
// IQ mixer/accumulator: multiplies each accepted ADC sample by the I and Q oscillator
// references and integrates 2**NSAMP_LOG2 products into one block sum per channel.
// Latency: acceptance to accumulate is LUT_LAT+2 cycles; block result appears one cycle after the last MAC.
// Backpressure: none; adc_valid outside IDLE is dropped and recorded in the sticky drop flag.
// Optional saturating accumulation: define IQ_MIXER_ACCUM_SAT_EN (adds the sat output).
module iq_mixer_accum #(
    parameter int DW         = 12,
    parameter int NSAMP_LOG2 = 8,
    parameter int AW         = 2*DW + NSAMP_LOG2,
    parameter int LUT_LAT    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 adc_valid,
    input  logic signed [DW-1:0] adc_sample,
    input  logic signed [DW-1:0] ref_i,
    input  logic signed [DW-1:0] ref_q,
    output logic                 next_sample,
    output logic signed [AW-1:0] i_acc,
    output logic signed [AW-1:0] q_acc,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 drop
`ifdef IQ_MIXER_ACCUM_SAT_EN
    ,
    output logic                 sat
`endif
);

    // Wait counter only ever holds LUT_LAT-1 down to 0.
    localparam int WCW = (LUT_LAT > 1) ? $clog2(LUT_LAT) : 1;
    localparam logic [WCW-1:0] WAIT_LOAD = WCW'(LUT_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        WAIT = 2'd2,
        MAC  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_accept;
    logic                    w_load;
    logic                    w_capture;
    logic                    w_mac;
    logic                    w_last;

    logic signed [DW-1:0]    r_sample;
    logic [WCW-1:0]          r_wcnt;
    logic signed [2*DW-1:0]  r_prod_i;
    logic signed [2*DW-1:0]  r_prod_q;
    logic signed [AW-1:0]    r_acc_i;
    logic signed [AW-1:0]    r_acc_q;
    logic [NSAMP_LOG2-1:0]   r_cnt;
    logic signed [AW-1:0]    r_i_acc;
    logic signed [AW-1:0]    r_q_acc;
    logic                    r_next_sample;
    logic                    r_out_valid;
    logic                    r_drop;

    logic signed [AW-1:0]    w_ext_i;
    logic signed [AW-1:0]    w_ext_q;
    logic signed [AW-1:0]    w_new_i;
    logic signed [AW-1:0]    w_new_q;

    // Products are full precision; sign-extend them to the accumulator width.
    assign w_ext_i = AW'(r_prod_i);
    assign w_ext_q = AW'(r_prod_q);
    assign w_last  = &r_cnt;

`ifdef IQ_MIXER_ACCUM_SAT_EN
    localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

    logic [AW:0] w_sum_i;
    logic [AW:0] w_sum_q;
    logic        w_ovf_i;
    logic        w_ovf_q;
    logic        r_sat;

    // One guard bit detects overflow: the top two bits disagree.
    assign w_sum_i = {r_acc_i[AW-1], r_acc_i} + {w_ext_i[AW-1], w_ext_i};
    assign w_sum_q = {r_acc_q[AW-1], r_acc_q} + {w_ext_q[AW-1], w_ext_q};
    assign w_ovf_i = w_sum_i[AW] ^ w_sum_i[AW-1];
    assign w_ovf_q = w_sum_q[AW] ^ w_sum_q[AW-1];
    assign w_new_i = w_ovf_i ? (w_sum_i[AW] ? ACC_MIN : ACC_MAX) : w_sum_i[AW-1:0];
    assign w_new_q = w_ovf_q ? (w_sum_q[AW] ? ACC_MIN : ACC_MAX) : w_sum_q[AW-1:0];
    assign sat     = r_sat;

    // Sticky per-block saturation flag; it is visible alongside out_valid and cleared right after.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat <= 1'b0;
        end else if (r_out_valid) begin
            r_sat <= 1'b0;
        end else if (w_mac) begin
            r_sat <= r_sat | w_ovf_i | w_ovf_q;
        end
    end
`else
    assign w_new_i = r_acc_i + w_ext_i;
    assign w_new_q = r_acc_q + w_ext_q;
`endif

    // State register; reset returns to IDLE regardless of adc_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-state action strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        w_mac       = 1'b0;
        case (r_state)
            IDLE: begin
                if (adc_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = STEP;
                end
            end
            STEP: begin
                w_load      = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (r_wcnt == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = MAC;
                end
            end
            MAC: begin
                w_mac       = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: sample latch, LUT wait, multiply, accumulate and block hand-off.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample      <= '0;
            r_wcnt        <= '0;
            r_prod_i      <= '0;
            r_prod_q      <= '0;
            r_acc_i       <= '0;
            r_acc_q       <= '0;
            r_cnt         <= '0;
            r_i_acc       <= '0;
            r_q_acc       <= '0;
            r_next_sample <= 1'b0;
            r_out_valid   <= 1'b0;
        end else begin
            // Registered so the oscillator step lines up with the STEP state.
            r_next_sample <= w_accept;
            r_out_valid   <= 1'b0;
            if (w_accept) begin
                r_sample <= adc_sample;
            end
            if (w_load) begin
                r_wcnt <= WAIT_LOAD;
            end else if (r_state == WAIT && r_wcnt != '0) begin
                r_wcnt <= r_wcnt - 1'b1;
            end
            if (w_capture) begin
                r_prod_i <= r_sample * ref_i;
                r_prod_q <= r_sample * ref_q;
            end
            if (w_mac) begin
                if (w_last) begin
                    // Publish the sum including this sample and restart the block in the same edge.
                    r_i_acc     <= w_new_i;
                    r_q_acc     <= w_new_q;
                    r_out_valid <= 1'b1;
                    r_acc_i     <= '0;
                    r_acc_q     <= '0;
                    r_cnt       <= '0;
                end else begin
                    r_acc_i <= w_new_i;
                    r_acc_q <= w_new_q;
                    r_cnt   <= r_cnt + 1'b1;
                end
            end
        end
    end

    // Sticky overrun flag: any strobe outside IDLE is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop <= 1'b0;
        end else if (adc_valid && r_state != IDLE) begin
            r_drop <= 1'b1;
        end
    end

    assign next_sample = r_next_sample;
    assign i_acc       = r_i_acc;
    assign q_acc       = r_q_acc;
    assign out_valid   = r_out_valid;
    assign busy        = (r_state != IDLE);
    assign drop        = r_drop;

endmodule
